dog_subtract: RTL and testbench
===============================

Name: dog_subtract

Overview:
- Difference-of-Gaussians stage directly downstream of two Gaussian blur instances (scale sigma_a, sigma_b) fed from the same pixel stream and Clk_en.
- Skew-aligns the two blurred streams, discards vertical-filter warm-up pixels, emits a signed 9-bit DoG stream with line/frame markers.
- Feeds the extrema detector.

Parameters:
- IMG_W, 400, pixels per line.
- IMG_H, 300, lines per frame.
- WARMUP, 800, enabled cycles discarded after Frame_start (Gaussian vertical fill, 2 lines).
- SKEW, 0, Clk_en cycles din_a is delayed to align with din_b; 0..15; 0 = no delay stage.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Clk_en  in  1  pixel-advance enable, shared with the upstream Gaussians.
- Frame_start  in  1  one-cycle pulse marking the first pixel of a frame on din_a/din_b.
- din_a  in  8  Gaussian output, smaller sigma.
- din_b  in  8  Gaussian output, larger sigma.
- dout  out  9  signed two's-complement DoG = a_aligned - din_b.
- dout_valid  out  1  dout is a frame pixel.
- dout_sol  out  1  start of line (col 0), qualified by dout_valid.
- dout_eof  out  1  last pixel of frame, qualified by dout_valid.
- busy  out  1  state != IDLE.
- max_abs  out  8  per-frame max |dout| (see Optional Feature).

Behaviour:
- Reset (async, active-high): all outputs 0, delay line cleared, counters 0, state IDLE.
- Clk_en low: nothing advances. Delay line, counters and state hold. dout_valid/sol/eof forced 0 that cycle. dout holds.
- Frame_start is sampled only when Clk_en=1; ignored otherwise.
- Alignment: a_aligned = din_a delayed SKEW enabled cycles. Difference = zero-extend(a_aligned) - zero-extend(din_b), 9-bit, range -255..255, no saturation.
- dout is registered: 1 enabled cycle latency from the din_b sample to dout.
- States:
  - IDLE: no output. Frame_start -> WARMUP, pix_cnt=0.
  - WARMUP: pix_cnt counts enabled cycles. The Frame_start cycle counts as 0. When pix_cnt reaches WARMUP-1 -> RUN, col=0, row=0. WARMUP=0 means Frame_start enters RUN directly and that cycle is pixel (0,0).
  - RUN: each enabled cycle emits a pixel (valid=1), col++. col wraps IMG_W-1 -> 0 with row++. Pixel (IMG_W-1, IMG_H-1) asserts dout_eof, then -> IDLE.
- Flag timing: dout_sol/dout_eof/dout_valid are registered alongside dout, same latency.
- Frame_start in WARMUP or RUN restarts: counters 0, -> WARMUP. Any pixel being emitted that cycle still emits normally.
- Frame_start on the eof cycle: eof pixel emitted, next state WARMUP (not IDLE).
- Reset mid-frame: immediate abort to IDLE, no eof.

Optional Feature:
- Macro DOG_STATS_EN.
- Defined: max_abs tracks the largest |dout| over valid pixels of the current frame. It updates the cycle after each valid pixel and clears to 0 on Frame_start. |-255| = 255, fits in 8 bits.
- Undefined: max_abs tied to 0, no tracking logic synthesized.

Decomposition:
- Package dog_pkg: state encoding (IDLE, WARMUP, RUN), pixel width 8, DoG width 9, counter-width function clog2.
- Sub-module dog_delay_line: parameterised SKEW-deep, 8-bit, Clk_en-gated shift register with async clear. SKEW=0 passes through combinationally.

Test Plan (IMG_W=4, IMG_H=2, WARMUP=8, SKEW=2 unless stated):
- Frame_start, Clk_en=1 constant, din_a=100, din_b=60 -> first dout_valid 9 cycles after the Frame_start edge, dout=+40, exactly 8 valid pixels, dout_sol on pixels 0 and 4, dout_eof on pixel 7, busy then falls.
- SKEW=2, din_a ramp 0,1,2,..., din_b ramp 0,1,2,... -> dout = -2 on every valid pixel.
- din_a=0, din_b=255 -> dout=9'h101 (-255). With DOG_STATS_EN, max_abs=255 after the pixel.
- Clk_en toggled 1,0,1,0 during RUN -> valid only on enabled cycles, no pixel dropped or duplicated, eof still on the 8th pixel.
- Frame_start asserted at RUN pixel 5 -> pixel 5 emitted, no eof, 8 warm-up cycles, then a fresh frame from col 0 row 0.
- Reset asserted mid-RUN, asynchronously between edges -> all outputs 0 immediately, busy=0, no further valid until a new Frame_start.

Source files
------------

// File: rtl/dog_pkg.sv
// Shared types and helpers for the difference-of-Gaussians stage.
package dog_pkg;

    localparam int PIX_W = 8;
    localparam int DOG_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } dog_state_e;

    // Counter width for values 0..n-1; never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/dog_delay_line.sv
// Enable-gated 8-bit shift register aligning the smaller-sigma stream; depth 0 is a wire.
module dog_delay_line
    import dog_pkg::*;
#(
    parameter int SKEW = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [PIX_W-1:0] din_i,
    output logic [PIX_W-1:0] dout_o
);

    generate
        if (SKEW == 0) begin : g_pass
            logic unused_sig;
            assign unused_sig = &{1'b0, clk_i, rst_i, en_i};
            assign dout_o     = din_i;
        end else begin : g_taps
            logic [PIX_W-1:0] taps_q [SKEW];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < SKEW; i++) taps_q[i] <= '0;
                end else if (en_i) begin
                    taps_q[0] <= din_i;
                    for (int i = 1; i < SKEW; i++) taps_q[i] <= taps_q[i-1];
                end
            end

            assign dout_o = taps_q[SKEW-1];
        end
    endgenerate

endmodule

// File: rtl/dog_subtract.sv
// DoG stage: aligns two blurred streams, drops vertical warm-up, emits signed a-b with markers.
// Optional per-frame max |dout| tracking is built when DOG_STATS_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no frame in progress, waiting for Frame_start
// ST_WARMUP | discarding enabled cycles while the Gaussians fill
// ST_RUN    | every enabled cycle is a frame pixel
module dog_subtract
    import dog_pkg::*;
#(
    parameter int IMG_W  = 400,
    parameter int IMG_H  = 300,
    parameter int WARMUP = 800,
    parameter int SKEW   = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clk_en,
    input  logic             Frame_start,
    input  logic [PIX_W-1:0] din_a,
    input  logic [PIX_W-1:0] din_b,
    output logic [DOG_W-1:0] dout,
    output logic             dout_valid,
    output logic             dout_sol,
    output logic             dout_eof,
    output logic             busy,
    output logic [PIX_W-1:0] max_abs
);

    localparam int COL_W = clog2(IMG_W);
    localparam int ROW_W = clog2(IMG_H);
    localparam int WU_W  = clog2(WARMUP + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [WU_W-1:0]  WU_LOAD  = WU_W'(WARMUP - 2);

    dog_state_e       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [WU_W-1:0]  wu_q, wu_d;
    logic [DOG_W-1:0] dout_q;
    logic             valid_q, sol_q, eof_q;

    logic [PIX_W-1:0] a_aligned;
    logic [DOG_W-1:0] diff;
    logic             start_pix, emit, pix_sol, pix_eof;
    logic [COL_W-1:0] pix_col, nxt_col;
    logic [ROW_W-1:0] pix_row, nxt_row;

    dog_delay_line #(.SKEW(SKEW)) u_delay (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .en_i   (Clk_en),
        .din_i  (din_a),
        .dout_o (a_aligned)
    );

    assign diff = {1'b0, a_aligned} - {1'b0, din_b};

    // With no warm-up the Frame_start cycle itself is pixel (0,0).
    assign start_pix = Frame_start && (WARMUP == 0);
    assign emit      = (state_q == ST_RUN) || start_pix;
    assign pix_col   = start_pix ? '0 : col_q;
    assign pix_row   = start_pix ? '0 : row_q;
    assign pix_sol   = (pix_col == '0);
    assign pix_eof   = (pix_col == COL_LAST) && (pix_row == ROW_LAST);
    assign nxt_col   = (pix_col == COL_LAST) ? '0 : pix_col + 1'b1;
    assign nxt_row   = (pix_col == COL_LAST) ? pix_row + 1'b1 : pix_row;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        wu_d    = wu_q;
        if (Frame_start) begin
            col_d = '0;
            row_d = '0;
            wu_d  = '0;
            if (WARMUP == 0) begin
                if (pix_eof) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                    col_d   = nxt_col;
                    row_d   = nxt_row;
                end
            end else if (WARMUP == 1) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_WARMUP;
                wu_d    = WU_LOAD;
            end
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    if (wu_q == '0) begin
                        state_d = ST_RUN;
                        col_d   = '0;
                        row_d   = '0;
                    end else begin
                        wu_d = wu_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pix_eof) begin
                        state_d = ST_IDLE;
                    end else begin
                        col_d = nxt_col;
                        row_d = nxt_row;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            wu_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            sol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else if (Clk_en) begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            wu_q    <= wu_d;
            dout_q  <= diff;
            valid_q <= emit;
            sol_q   <= emit && pix_sol;
            eof_q   <= emit && pix_eof;
        end else begin
            valid_q <= 1'b0;
            sol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign dout_sol   = sol_q;
    assign dout_eof   = eof_q;
    assign busy       = (state_q != ST_IDLE);

`ifdef DOG_STATS_EN
    logic [PIX_W-1:0] max_abs_q;
    logic [DOG_W-1:0] neg_dout;
    logic [PIX_W-1:0] abs_dout;

    assign neg_dout = -dout_q;
    assign abs_dout = dout_q[DOG_W-1] ? neg_dout[PIX_W-1:0] : dout_q[PIX_W-1:0];

    // valid_q lasts exactly one clock, so the update is deliberately not Clk_en-gated.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            max_abs_q <= '0;
        end else if (Clk_en && Frame_start) begin
            max_abs_q <= '0;
        end else if (valid_q && (abs_dout > max_abs_q)) begin
            max_abs_q <= abs_dout;
        end
    end

    assign max_abs = max_abs_q;
`else
    assign max_abs = '0;
`endif

endmodule

// File: tb/tb_dog_subtract.sv
// Directed bench for dog_subtract at IMG_W=4, IMG_H=2, WARMUP=8, SKEW=2.
module tb_dog_subtract;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Clk_en;
    logic       Frame_start;
    logic [7:0] din_a;
    logic [7:0] din_b;
    logic [8:0] dout;
    logic       dout_valid;
    logic       dout_sol;
    logic       dout_eof;
    logic       busy;
    logic [7:0] max_abs;

`ifdef DOG_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int n_chk = 0;
    int n_bad = 0;
    int step_n;
    int q_dout[$];
    int q_sol[$];
    int q_eof[$];
    int q_step[$];

    always #5 Clk = ~Clk;

    dog_subtract #(
        .IMG_W  (4),
        .IMG_H  (2),
        .WARMUP (8),
        .SKEW   (2)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Clk_en      (Clk_en),
        .Frame_start (Frame_start),
        .din_a       (din_a),
        .din_b       (din_b),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_sol    (dout_sol),
        .dout_eof    (dout_eof),
        .busy        (busy),
        .max_abs     (max_abs)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        step_n++;
        if (dout_valid) begin
            q_dout.push_back(int'(dout));
            q_sol.push_back(int'(dout_sol));
            q_eof.push_back(int'(dout_eof));
            q_step.push_back(step_n);
        end
    endtask

    task automatic clear_log();
        q_dout.delete();
        q_sol.delete();
        q_eof.delete();
        q_step.delete();
        step_n = 0;
    endtask

    task automatic check_frame(input string tag, input int exp_dout);
        check_eq({tag, "_npix"}, q_dout.size(), 8);
        for (int i = 0; i < q_dout.size() && i < 8; i++) begin
            check_eq($sformatf("%s_dout%0d", tag, i), q_dout[i], exp_dout);
            check_eq($sformatf("%s_sol%0d", tag, i), q_sol[i], (i % 4 == 0) ? 1 : 0);
            check_eq($sformatf("%s_eof%0d", tag, i), q_eof[i], (i == 7) ? 1 : 0);
        end
    endtask

    initial begin
        Reset       = 1'b1;
        Clk_en      = 1'b0;
        Frame_start = 1'b0;
        din_a       = 8'd0;
        din_b       = 8'd0;
        #12;
        check_eq("rst_dout", int'(dout), 0);
        check_eq("rst_valid", int'(dout_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_max", int'(max_abs), 0);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // Constant inputs: latency, pixel count, markers, busy fall
        clear_log();
        for (int c = 0; c < 20; c++) begin
            Clk_en      = 1'b1;
            Frame_start = (c == 0);
            din_a       = 8'd100;
            din_b       = 8'd60;
            tick();
            if (step_n == 1)  check_eq("c1_busy_warm", int'(busy), 1);
            if (step_n == 15) check_eq("c1_busy_run", int'(busy), 1);
            if (step_n == 16) check_eq("c1_busy_fall", int'(busy), 0);
        end
        check_eq("c1_first_step", (q_step.size() > 0) ? q_step[0] : -1, 9);
        check_frame("c1", 40);
        check_eq("c1_max", int'(max_abs), STATS ? 40 : 0);

        // Equal ramps with SKEW=2 give a constant -2
        clear_log();
        for (int c = 0; c < 20; c++) begin
            Frame_start = (c == 0);
            din_a       = 8'(c);
            din_b       = 8'(c);
            tick();
            if (step_n == 1) check_eq("c2_max_clear", int'(max_abs), 0);
        end
        check_frame("c2", 9'h1FE);
        check_eq("c2_max", int'(max_abs), STATS ? 2 : 0);

        // Full-scale negative difference
        clear_log();
        for (int c = 0; c < 20; c++) begin
            Frame_start = (c == 0);
            din_a       = 8'd0;
            din_b       = 8'd255;
            tick();
        end
        check_frame("c3", 9'h101);
        check_eq("c3_max", int'(max_abs), STATS ? 255 : 0);

        // Clk_en toggling in RUN; a Frame_start on a disabled cycle is ignored
        clear_log();
        for (int c = 0; c < 30; c++) begin
            if (c < 8) begin
                Clk_en = 1'b1;
                din_a  = 8'd200;
                din_b  = 8'd0;
            end else if ((c - 8) % 2 == 0) begin
                Clk_en = 1'b1;
                din_a  = 8'd200;
                din_b  = 8'(((c - 8) / 2) * 10);
            end else begin
                Clk_en = 1'b0;
                din_a  = 8'd5;
                din_b  = 8'd77;
            end
            Frame_start = (c == 0) || (c == 11);
            tick();
        end
        Clk_en = 1'b1;
        check_eq("c4_npix", q_dout.size(), 8);
        for (int i = 0; i < q_dout.size() && i < 8; i++) begin
            check_eq($sformatf("c4_dout%0d", i), q_dout[i], 200 - 10 * i);
            check_eq($sformatf("c4_step%0d", i), q_step[i], 9 + 2 * i);
            check_eq($sformatf("c4_eof%0d", i), q_eof[i], (i == 7) ? 1 : 0);
        end

        // Restart at RUN pixel 5
        clear_log();
        for (int c = 0; c < 35; c++) begin
            Frame_start = (c == 0) || (c == 13);
            din_a       = 8'd100;
            din_b       = 8'd60;
            tick();
        end
        check_eq("c5_npix", q_dout.size(), 14);
        if (q_dout.size() == 14) begin
            check_eq("c5_p5_step", q_step[5], 14);
            check_eq("c5_p5_eof", q_eof[5], 0);
            check_eq("c5_new_step", q_step[6], 22);
            check_eq("c5_new_sol", q_sol[6], 1);
            check_eq("c5_new_sol4", q_sol[10], 1);
            check_eq("c5_last_eof", q_eof[13], 1);
            check_eq("c5_eof_total", q_eof.sum(), 1);
        end

        // Asynchronous reset mid-RUN
        clear_log();
        for (int c = 0; c < 11; c++) begin
            Frame_start = (c == 0);
            din_a       = 8'd10;
            din_b       = 8'd3;
            tick();
        end
        check_eq("c6_valid_before", int'(dout_valid), 1);
        #3;
        Reset = 1'b1;
        #1;
        check_eq("c6_dout", int'(dout), 0);
        check_eq("c6_valid", int'(dout_valid), 0);
        check_eq("c6_sol", int'(dout_sol), 0);
        check_eq("c6_busy", int'(busy), 0);
        check_eq("c6_max", int'(max_abs), 0);
        @(negedge Clk);
        Reset = 1'b0;
        clear_log();
        Frame_start = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        check_eq("c6_no_valid", q_dout.size(), 0);
        check_eq("c6_busy_after", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
